sum_result_fifo: RTL

- Downstream consumer of the adder stage. Captures each valid sum the adder produces and buffers it in a first-word-fall-through FIFO.
- Presents buffered sums to the next stage over a valid/ready handshake.
- Tracks occupancy, a high-water mark and a sticky overflow flag, so the bench and scoreboard can detect sums that were dropped.

---
 rtl/sum_result_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/sum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_fifo
// Brief    : First-word-fall-through FIFO that buffers adder sums. It tracks
//            occupancy, a high-water mark and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module sum_result_fifo #(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  hwm,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_hwm;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [CNT_W-1:0]  w_count_nxt;

    // Full/empty come from the registered count; the pointers alone cannot
    // tell a full buffer from an empty one.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_pop       = !w_empty && out_ready;
        w_push      = in_valid && (!w_full || w_pop);
        w_drop      = in_valid && w_full && !w_pop;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_hwm      <= '0;
            r_overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by natural rollover.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; out_data is don't-care while empty.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign hwm       = r_hwm;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
